// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the line with a fixed clock divisor and
// emits each correctly framed byte together with a one-cycle strobe.
module uart_rx #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] uart_rx_byte,
  output logic       uart_rx_irq,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  localparam int N  = SYS_CLK_FREQ / BAUD_RATE;
  localparam int H  = (N - 1) / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_HALF = CW'(H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_irq;
  logic            r_ferr;
  logic            w_rx_s;

  assign w_rx_s = r_sync[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_byte    <= 8'h00;
      r_irq     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_irq  <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          // Re-check the start bit near its centre to reject glitches.
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_byte  <= r_shift;
              r_irq   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A line held low must return high before a new start bit counts.
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_rx_byte = r_byte;
  assign uart_rx_irq  = r_irq;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at N=16, H=7: the driver queues expected bytes
// and pulse cycles, a monitor checks every strobe the receiver presents.
module tb_uart_rx;

  logic       clk;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] uart_rx_byte;
  logic       uart_rx_irq;
  logic       frame_err;
  logic       busy;
  logic [2:0] o_dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_t_q[$];
  logic [31:0] ferr_t_q[$];
  logic [7:0]  last_good = 8'h00;
  logic        glitch_busy_seen = 1'b0;
  logic        prev_irq = 1'b0;
  logic        prev_ferr = 1'b0;

  uart_rx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .uart_rx_byte (uart_rx_byte),
    .uart_rx_irq  (uart_rx_irq),
    .frame_err    (frame_err),
    .busy         (busy),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame; the strobe is due in the cycle after edge T0+154,
  // where T0 is the edge right after rx_i goes low.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(data);
      exp_t_q.push_back(cyc + 155);
    end else begin
      ferr_t_q.push_back(cyc + 155);
    end
    rx_i = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      tick(16);
    end
    rx_i = stop_bit;
    tick(16);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte"}, 32'(uart_rx_byte), 32'h00);
    chk({tag, "_irq"},  32'(uart_rx_irq),  32'h0);
    chk({tag, "_ferr"}, 32'(frame_err),    32'h0);
    chk({tag, "_busy"}, 32'(busy),         32'h0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_i) begin
      last_good = 8'h00;
    end else begin
      if (busy) glitch_busy_seen = 1'b1;
      if (prev_irq) chk("irq_width", 32'(uart_rx_irq), 32'h0);
      if (prev_ferr) chk("ferr_width", 32'(frame_err), 32'h0);
      if (uart_rx_irq && frame_err) chk("irq_ferr_exclusive", 32'h1, 32'h0);
      if (uart_rx_irq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_irq", 32'h1, 32'h0);
        end else begin
          logic [7:0]  e_byte;
          logic [31:0] e_t;
          e_byte = exp_q.pop_front();
          e_t    = exp_t_q.pop_front();
          chk("rx_byte", 32'(uart_rx_byte), 32'(e_byte));
          chk("irq_cycle", 32'(cyc), e_t);
          chk("busy_at_irq", 32'(busy), 32'h0);
          last_good = e_byte;
        end
      end
      if (frame_err) begin
        if (ferr_t_q.size() == 0) begin
          chk("unexpected_ferr", 32'h1, 32'h0);
        end else begin
          chk("ferr_cycle", 32'(cyc), ferr_t_q.pop_front());
          chk("byte_kept_on_ferr", 32'(uart_rx_byte), 32'(last_good));
        end
      end
    end
    prev_irq  = uart_rx_irq;
    prev_ferr = frame_err;
  end

  // Driver
  initial begin
    int budget;
    reset_i = 1'b1;
    rx_i    = 1'b1;
    tick(3);
    check_reset_outputs("por");
    reset_i = 1'b0;
    tick(500);

    reset_i = 1'b1;
    tick(2);
    check_reset_outputs("idle_reset");
    reset_i = 1'b0;
    tick(20);

    send_frame(8'h2D, 1'b1);
    tick(30);

    send_frame(8'h2D, 1'b1);
    send_frame(8'h70, 1'b1);
    send_frame(8'h5F, 1'b1);
    tick(30);

    glitch_busy_seen = 1'b0;
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    tick(20);
    chk("glitch_busy_seen", 32'(glitch_busy_seen), 32'h1);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    chk("glitch_state_idle", 32'(o_dbg_state), 32'h0);
    chk("glitch_byte_kept", 32'(uart_rx_byte), 32'h5F);

    send_frame(8'hA5, 1'b0);
    tick(100);
    chk("break_byte_kept", 32'(uart_rx_byte), 32'h5F);
    chk("break_busy", 32'(busy), 32'h1);
    rx_i = 1'b1;
    tick(20);
    chk("break_released_idle", 32'(o_dbg_state), 32'h0);
    send_frame(8'h3C, 1'b1);
    tick(30);

    // 0xFF aborted by reset in the middle of data bit 4
    rx_i = 1'b0;
    tick(16);
    rx_i = 1'b1;
    tick(72);
    reset_i = 1'b1;
    tick(2);
    check_reset_outputs("midframe_reset");
    reset_i = 1'b0;
    tick(40);
    chk("midframe_state_idle", 32'(o_dbg_state), 32'h0);
    send_frame(8'h11, 1'b1);

    budget = 400;
    while ((exp_q.size() != 0 || ferr_t_q.size() != 0) && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(5);
    chk("irq_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("ferr_queue_drained", 32'(ferr_t_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver (8N1, LSB first) that converts the board's UART RX pin into byte/strobe pairs. It sits directly upstream of the boot loader FSM and drives that block's `uart_rx_irq` and `uart_rx_byte` inputs. It also feeds the same stream to any other byte consumer, such as the instruction-memory writer. It runs on the system clock and derives bit timing from a fixed integer divisor.

## Interface

Parameters:
- `SYS_CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- Derived constants:
  - `N` = `SYS_CLK_FREQ / BAUD_RATE`, integer truncation (868 at defaults). `N` ≥ 4 is required.
  - `H` = `(N-1)/2`, integer truncation (433 at defaults).

Ports (the clock and reset are one clock; reset is asynchronous and active-high):
- `clk_i`  input  1  system clock; all state changes on its rising edge.
- `reset_i`  input  1  asynchronous, active-high reset.
- `rx_i`  input  1  serial line; idles high; asynchronous to `clk_i`.
- `uart_rx_byte`  output  8  last correctly framed byte; holds its value until the next good frame.
- `uart_rx_irq`  output  1  one-cycle pulse; `uart_rx_byte` is valid and newly updated in the same cycle.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `busy`  output  1  high in every state other than IDLE.

## Operation

- **Input synchronizer:** 2-flop chain on `rx_i`, both flops reset to 1. The FSM uses only the second flop, `rx_s`.
- **Counter:** one bit-timing counter, 0 to `N-1`. It is cleared on every state transition and increments every cycle otherwise.
- **Data capture:** 3-bit bit index and 8-bit shift register. Each sample shifts right with the new bit entering at bit 7, so after 8 samples the first-received bit sits at bit 0.
- **States:**
  - IDLE:
    - `rx_s`=0 → START.
  - START:
    - On counter == `H`, sample `rx_s`.
    - Sample 0 → DATA, bit index = 0.
    - Sample 1 → IDLE (glitch rejected, no output).
  - DATA:
    - On counter == `N-1`, sample `rx_s` into the shift register and increment the bit index.
    - After the 8th sample → STOP.
  - STOP:
    - On counter == `N-1`, sample `rx_s`.
    - Sample 1: load `uart_rx_byte` from the shift register, pulse `uart_rx_irq`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `uart_rx_byte` unchanged, go to BREAK.
  - BREAK:
    - Wait for `rx_s`=1, then → IDLE. A held-low line (break) must not produce repeated frames.
- `uart_rx_irq` and `frame_err` are registered and never high together.
- **Reset:**
  - Async reset at any time, including mid-frame, forces IDLE, counter 0, bit index 0, shift register 0, synchronizer 1.
  - Outputs after reset: `uart_rx_byte` = 0x00, `uart_rx_irq` = 0, `frame_err` = 0, `busy` = 0.
  - A partially received frame is discarded without any pulse.
- There is no receive FIFO and no back-pressure. The consumer must take the byte in the `uart_rx_irq` cycle.

## Timing

- Let T0 be the first `clk_i` edge that samples `rx_i` low.
  - `rx_s` is low after edge T0+1.
  - START is entered at edge T0+2.
  - DATA is entered at edge T0+3+`H`.
  - STOP is entered at edge T0+3+`H`+8`N`.
  - `uart_rx_irq` (or `frame_err`) is high for exactly the one cycle following edge T0+3+`H`+9`N`. At defaults this is T0+8248.
- **Sample points:**
  - Start bit: `H` cycles after START entry, near the bit centre.
  - Data and stop bits: every `N` cycles after that.
- **Back-to-back frames:** IDLE is entered in the same edge as the pulse, so a start bit arriving right after the stop bit is detected on the next cycle with `rx_s`=0. No idle gap is required beyond the stop bit.
- `busy` rises at edge T0+2 and falls at the edge that enters IDLE.

## Test plan

All scenarios run with `SYS_CLK_FREQ`=16 and `BAUD_RATE`=1, giving `N`=16 and `H`=7.

- **Reset values:** assert `reset_i` mid-idle → all outputs 0 and `uart_rx_byte`=0x00. Release it with `rx_i`=1 → no pulses for 500 cycles.
- **Single byte:** send 0x2D (8N1) → exactly one `uart_rx_irq` pulse, 1 cycle wide, with `uart_rx_byte`=0x2D. The pulse appears in the cycle after edge T0+3+7+144 = T0+154, and `frame_err` stays 0.
- **Back-to-back bytes:** send 0x2D, 0x70, 0x5F with no idle gap → three pulses, exactly 160 cycles apart, with bytes 0x2D, 0x70, 0x5F in order.
- **Glitch rejection:** drive `rx_i` low for 5 cycles, then high → `busy` pulses, no `uart_rx_irq`, no `frame_err`, FSM back in IDLE.
- **Framing error and break:**
  - Send 0xA5 with the stop bit low, then hold `rx_i` low for 100 cycles → one `frame_err` pulse, `uart_rx_byte` keeps its previous value, no further pulses while the line stays low.
  - Release the line and send 0x3C → `uart_rx_irq` with 0x3C.
- **Reset mid-frame:** assert `reset_i` during data bit 4 of 0xFF, release it, then send 0x11 → no pulse for the aborted frame, one pulse with 0x11.
